// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters, the arbiter and the register-file write port.
// The slave side is the arbiter; the master side is the requesters plus the register file.
interface regfile_wb_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic                   a_valid;
   logic                   a_ready;
   logic [ADDR_W-1:0]      a_dest;
   logic [DATA_W-1:0]      a_data;
   logic                   b_valid;
   logic                   b_ready;
   logic [ADDR_W-1:0]      b_dest;
   logic [DATA_W-1:0]      b_data;
   logic                   rf_load;
   logic [ADDR_W-1:0]      rf_dest;
   logic [DATA_W-1:0]      rf_in;
   logic [2**ADDR_W-1:0]   pending_mask;

   modport slave (
      input  a_valid, a_dest, a_data,
      input  b_valid, b_dest, b_data,
      output a_ready, b_ready,
      output rf_load, rf_dest, rf_in,
      output pending_mask
   );

   modport master (
      output a_valid, a_dest, a_data,
      output b_valid, b_dest, b_data,
      input  a_ready, b_ready,
      input  rf_load, rf_dest, rf_in,
      input  pending_mask
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between requester A (execute) and B (load).
// One-entry holding buffer per requester; the oldest buffered write is drained each cycle, ties go to A.
module regfile_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   regfile_wb_arbiter_if.slave    wb
);
   localparam int         NREG    = 2**ADDR_W;
   localparam logic [1:0] AGE_MAX = 2'd3;

   // index 0 = requester A, index 1 = requester B
   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [ADDR_W-1:0] req_dest [2];
   logic [DATA_W-1:0] req_data [2];

   logic [1:0]        full;
   logic [ADDR_W-1:0] buf_dest [2];
   logic [DATA_W-1:0] buf_data [2];
   logic [1:0]        age      [2];

   logic [1:0]        grant;
   logic [NREG-1:0]   pending;

   assign req_valid   = {wb.b_valid, wb.a_valid};
   assign req_dest[0] = wb.a_dest;
   assign req_dest[1] = wb.b_dest;
   assign req_data[0] = wb.a_data;
   assign req_data[1] = wb.b_data;

   // Ready depends only on buffer state, so a drained buffer cannot refill in its grant cycle.
   assign req_ready  = ~full & {2{~rst}};
   assign wb.a_ready = req_ready[0];
   assign wb.b_ready = req_ready[1];

   always_comb begin
      grant = 2'b00;
      if (!rst) begin
         if (full[0] && (!full[1] || age[0] >= age[1])) begin
            grant[0] = 1'b1;
         end else if (full[1]) begin
            grant[1] = 1'b1;
         end
      end
   end

   always_comb begin
      wb.rf_load = 1'b0;
      wb.rf_dest = '0;
      wb.rf_in   = '0;
      if (grant[0]) begin
         wb.rf_load = 1'b1;
         wb.rf_dest = buf_dest[0];
         wb.rf_in   = buf_data[0];
      end else if (grant[1]) begin
         wb.rf_load = 1'b1;
         wb.rf_dest = buf_dest[1];
         wb.rf_in   = buf_data[1];
      end
   end

   always_comb begin
      pending = '0;
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            if (full[i]) begin
               pending[buf_dest[i]] = 1'b1;
            end
         end
      end
   end

   assign wb.pending_mask = pending;

   always_ff @(posedge clk) begin
      if (rst) begin
         full <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            buf_dest[i] <= '0;
            buf_data[i] <= '0;
            age[i]      <= 2'd0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (grant[i]) begin
               full[i] <= 1'b0;
               age[i]  <= 2'd0;
            end else if (full[i]) begin
               if (age[i] != AGE_MAX) begin
                  age[i] <= age[i] + 2'd1;
               end
            end else if (req_valid[i] && req_ready[i]) begin
               // writes to register 0 complete the handshake but are dropped here
               full[i]     <= (req_dest[i] != '0);
               buf_dest[i] <= req_dest[i];
               buf_data[i] <= req_data[i];
               age[i]      <= 2'd0;
            end
         end
      end
   end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a write-order scoreboard.
module tb_regfile_wb_arbiter;
   localparam int DW = 32;
   localparam int AW = 5;

   typedef struct packed {
      logic [AW-1:0] dest;
      logic [DW-1:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   wr_t  sb[$];

   regfile_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk (clk),
      .rst (rst),
      .wb  (bus)
   );

   always #5 clk = ~clk;

   // Every register-file write must be the oldest outstanding expected write.
   always @(negedge clk) begin
      wr_t exp_w;
      n_checks++;
      if (bus.rf_load === 1'b1) begin
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: got dest=%0d data=%h, none expected", bus.rf_dest, bus.rf_in);
         end else begin
            exp_w = sb.pop_front();
            if ({bus.rf_dest, bus.rf_in} !== exp_w) begin
               n_fail++;
               $display("FAIL write_order: got dest=%0d data=%h, expected dest=%0d data=%h",
                        bus.rf_dest, bus.rf_in, exp_w.dest, exp_w.data);
            end
         end
      end else if (bus.rf_load !== 1'b0 || bus.rf_dest !== '0 || bus.rf_in !== '0) begin
         n_fail++;
         $display("FAIL idle_outputs: got load=%b dest=%h data=%h, expected 0/0/0", bus.rf_load, bus.rf_dest, bus.rf_in);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] bit_of(input int idx);
      logic [31:0] one;
      one = 32'd1;
      return one << idx;
   endfunction

   task automatic test_reset();
      bus.a_valid = 1'b1; bus.a_dest = 5'd3; bus.a_data = 32'h1234_5678;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++; if (bus.a_ready !== 1'b0) begin n_fail++; $display("FAIL reset_a_ready: got %b expected 0", bus.a_ready); end
         n_checks++; if (bus.rf_load !== 1'b0) begin n_fail++; $display("FAIL reset_rf_load: got %b expected 0", bus.rf_load); end
         n_checks++; if (bus.pending_mask !== 32'd0) begin n_fail++; $display("FAIL reset_pending: got %h expected 0", bus.pending_mask); end
      end
      rst = 1'b0;
      bus.a_valid = 1'b0;
      #1;
      n_checks++; if (bus.a_ready !== 1'b1) begin n_fail++; $display("FAIL release_a_ready: got %b expected 1", bus.a_ready); end
      tick();
      n_checks++; if (bus.rf_load !== 1'b0) begin n_fail++; $display("FAIL release_rf_load: got %b expected 0", bus.rf_load); end
      n_checks++; if (bus.pending_mask !== 32'd0) begin n_fail++; $display("FAIL release_pending: got %h expected 0", bus.pending_mask); end
   endtask

   task automatic test_single_write();
      bus.a_valid = 1'b1; bus.a_dest = 5'd5; bus.a_data = 32'hDEAD_BEEF;
      sb.push_back('{dest: 5'd5, data: 32'hDEAD_BEEF});
      tick();
      bus.a_valid = 1'b0;
      n_checks++; if (bus.pending_mask !== bit_of(5)) begin n_fail++; $display("FAIL single_pending: got %h expected %h", bus.pending_mask, bit_of(5)); end
      n_checks++; if (bus.rf_load !== 1'b1) begin n_fail++; $display("FAIL single_rf_load: got %b expected 1", bus.rf_load); end
      n_checks++; if (bus.rf_dest !== 5'd5) begin n_fail++; $display("FAIL single_rf_dest: got %0d expected 5", bus.rf_dest); end
      n_checks++; if (bus.rf_in !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_rf_in: got %h expected deadbeef", bus.rf_in); end
      n_checks++; if (bus.a_ready !== 1'b0) begin n_fail++; $display("FAIL single_busy_ready: got %b expected 0", bus.a_ready); end
      tick();
      n_checks++; if (bus.pending_mask !== 32'd0) begin n_fail++; $display("FAIL single_pending_clr: got %h expected 0", bus.pending_mask); end
      n_checks++; if (bus.a_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_back: got %b expected 1", bus.a_ready); end
   endtask

   task automatic test_simultaneous();
      bus.a_valid = 1'b1; bus.a_dest = 5'd7; bus.a_data = 32'h1;
      bus.b_valid = 1'b1; bus.b_dest = 5'd7; bus.b_data = 32'h2;
      sb.push_back('{dest: 5'd7, data: 32'h1});
      sb.push_back('{dest: 5'd7, data: 32'h2});
      tick();
      bus.a_valid = 1'b0; bus.b_valid = 1'b0;
      n_checks++; if (bus.rf_in !== 32'h1) begin n_fail++; $display("FAIL simul_first: got %h expected 1", bus.rf_in); end
      n_checks++; if (bus.pending_mask !== bit_of(7)) begin n_fail++; $display("FAIL simul_pending: got %h expected %h", bus.pending_mask, bit_of(7)); end
      n_checks++; if (bus.b_ready !== 1'b0) begin n_fail++; $display("FAIL simul_b_ready: got %b expected 0", bus.b_ready); end
      tick();
      n_checks++; if (bus.rf_load !== 1'b1 || bus.rf_in !== 32'h2) begin n_fail++; $display("FAIL simul_second: got load=%b data=%h expected 1/2", bus.rf_load, bus.rf_in); end
      n_checks++; if (bus.a_ready !== 1'b1) begin n_fail++; $display("FAIL simul_a_ready: got %b expected 1", bus.a_ready); end
      tick();
      n_checks++; if (bus.rf_load !== 1'b0 || bus.pending_mask !== 32'd0) begin n_fail++; $display("FAIL simul_drained: got load=%b mask=%h expected 0/0", bus.rf_load, bus.pending_mask); end
   endtask

   task automatic test_age_priority();
      bus.a_valid = 1'b1; bus.a_dest = 5'd2; bus.a_data = 32'hA000_0002;
      sb.push_back('{dest: 5'd2, data: 32'hA000_0002});
      tick();
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b1; bus.b_dest = 5'd4; bus.b_data = 32'hB000_0004;
      sb.push_back('{dest: 5'd4, data: 32'hB000_0004});
      n_checks++; if (bus.rf_dest !== 5'd2) begin n_fail++; $display("FAIL age_first: got %0d expected 2", bus.rf_dest); end
      tick();
      bus.b_valid = 1'b0;
      bus.a_valid = 1'b1; bus.a_dest = 5'd9; bus.a_data = 32'hA000_0009;
      sb.push_back('{dest: 5'd9, data: 32'hA000_0009});
      n_checks++; if (bus.rf_dest !== 5'd4) begin n_fail++; $display("FAIL age_b_granted: got %0d expected 4", bus.rf_dest); end
      n_checks++; if (bus.pending_mask !== bit_of(4)) begin n_fail++; $display("FAIL age_pending: got %h expected %h", bus.pending_mask, bit_of(4)); end
      tick();
      bus.a_valid = 1'b0;
      n_checks++; if (bus.rf_dest !== 5'd9) begin n_fail++; $display("FAIL age_last: got %0d expected 9", bus.rf_dest); end
      n_checks++; if (bus.b_ready !== 1'b1) begin n_fail++; $display("FAIL age_b_ready: got %b expected 1", bus.b_ready); end
      tick();
      n_checks++; if (bus.rf_load !== 1'b0) begin n_fail++; $display("FAIL age_idle: got %b expected 0", bus.rf_load); end
   endtask

   task automatic test_x0_drop();
      n_checks++; if (bus.b_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready_before: got %b expected 1", bus.b_ready); end
      bus.b_valid = 1'b1; bus.b_dest = 5'd0; bus.b_data = 32'hFFFF_FFFF;
      tick();
      bus.b_valid = 1'b0;
      n_checks++; if (bus.b_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready_after: got %b expected 1", bus.b_ready); end
      n_checks++; if (bus.rf_load !== 1'b0) begin n_fail++; $display("FAIL x0_rf_load: got %b expected 0", bus.rf_load); end
      n_checks++; if (bus.pending_mask !== 32'd0) begin n_fail++; $display("FAIL x0_pending: got %h expected 0", bus.pending_mask); end
      tick();
      n_checks++; if (bus.rf_load !== 1'b0) begin n_fail++; $display("FAIL x0_rf_load_late: got %b expected 0", bus.rf_load); end
   endtask

   // Both requesters stream continuously; writes must come out in accept order, A first on a tie.
   task automatic test_back_to_back();
      int n_writes;
      n_writes = 0;
      for (int i = 0; i < 16; i++) begin
         bus.a_valid = 1'b1; bus.a_dest = 5'((i % 15) + 1);  bus.a_data = $urandom;
         bus.b_valid = 1'b1; bus.b_dest = 5'((i % 15) + 16); bus.b_data = $urandom;
         if (bus.a_ready === 1'b1) sb.push_back('{dest: bus.a_dest, data: bus.a_data});
         if (bus.b_ready === 1'b1) sb.push_back('{dest: bus.b_dest, data: bus.b_data});
         tick();
         if (i >= 1 && bus.rf_load === 1'b1) n_writes++;
      end
      bus.a_valid = 1'b0; bus.b_valid = 1'b0;
      n_checks++; if (n_writes !== 15) begin n_fail++; $display("FAIL b2b_throughput: got %0d writes expected 15", n_writes); end
      repeat (4) tick();
      n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL b2b_drained: got %0d outstanding expected 0", sb.size()); end
      n_checks++; if (bus.pending_mask !== 32'd0) begin n_fail++; $display("FAIL b2b_pending: got %h expected 0", bus.pending_mask); end
   endtask

   task automatic test_reset_mid();
      bus.a_valid = 1'b1; bus.a_dest = 5'd10; bus.a_data = 32'h0000_0010;
      bus.b_valid = 1'b1; bus.b_dest = 5'd11; bus.b_data = 32'h0000_0011;
      tick();
      bus.a_valid = 1'b0; bus.b_valid = 1'b0;
      n_checks++; if (bus.pending_mask !== (bit_of(10) | bit_of(11))) begin n_fail++; $display("FAIL mid_loaded: got %h expected %h", bus.pending_mask, bit_of(10) | bit_of(11)); end
      rst = 1'b1;
      #1;
      n_checks++; if (bus.rf_load !== 1'b0 || bus.pending_mask !== 32'd0) begin n_fail++; $display("FAIL mid_rst_now: got load=%b mask=%h expected 0/0", bus.rf_load, bus.pending_mask); end
      tick();
      n_checks++; if (bus.rf_load !== 1'b0 || bus.pending_mask !== 32'd0) begin n_fail++; $display("FAIL mid_rst_next: got load=%b mask=%h expected 0/0", bus.rf_load, bus.pending_mask); end
      n_checks++; if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got a=%b b=%b expected 0/0", bus.a_ready, bus.b_ready); end
      rst = 1'b0;
      repeat (4) tick();
      n_checks++; if (bus.pending_mask !== 32'd0) begin n_fail++; $display("FAIL mid_after_pending: got %h expected 0", bus.pending_mask); end
      n_checks++; if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b1) begin n_fail++; $display("FAIL mid_after_ready: got a=%b b=%b expected 1/1", bus.a_ready, bus.b_ready); end
   endtask

   initial begin
      bus.a_valid = 1'b0; bus.a_dest = '0; bus.a_data = '0;
      bus.b_valid = 1'b0; bus.b_dest = '0; bus.b_data = '0;
      test_reset();
      test_single_write();
      test_simultaneous();
      test_age_priority();
      test_x0_drop();
      test_back_to_back();
      test_reset_mid();
      tick();
      n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL final_outstanding: got %0d expected 0", sb.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
